arb_xfer_ctrl: RTL and testbench

//  Downstream stage of the priority arbiter. Samples the one-hot grant and

---
 rtl/arb_xfer_ctrl.sv | 146 ++++++++++++++
 tb/tb_arb_xfer_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/arb_xfer_ctrl.sv
// Burst-locking transfer controller behind the priority arbiter: latches the granted
// owner until its last beat and forwards beats on a registered valid/ready channel.
// Optional stall abort in WAIT is enabled with `define ARB_XFER_STALL_TIMEOUT_EN.
module arb_xfer_ctrl #(
  parameter int N       = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N-1:0]                        req_valid,
  input  logic [N*DW-1:0]                     req_data,
  input  logic [N-1:0]                        req_last,
  input  logic [N-1:0]                        gnt,
  input  logic                                gnt_valid,
  output logic [N-1:0]                        req_pop,
  output logic                                out_valid,
  output logic [DW-1:0]                       out_data,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_id,
  output logic                                out_last,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                err_timeout
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N < 1 || DW < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("arb_xfer_ctrl: N, DW and TIMEOUT must all be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;

  state_e          state_q;
  logic [IW-1:0]   owner_q;
  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic [IW-1:0]   out_id_q;
  logic            out_last_q;

  logic [IW-1:0]   gnt_idx;
  logic            take_gnt;
  logic [IW-1:0]   sel_d;
  logic            load_d;

  // Lowest set bit wins, so a non-one-hot grant still resolves deterministically.
  always_comb begin
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (gnt[i]) gnt_idx = IW'(i);
  end

  assign take_gnt = (state_q == IDLE) && gnt_valid && (|gnt);
  assign sel_d    = (state_q == IDLE) ? gnt_idx : owner_q;

  always_comb begin
    load_d = 1'b0;
    case (state_q)
      IDLE:    load_d = take_gnt && req_valid[sel_d];
      SEND:    load_d = out_ready && !out_last_q && req_valid[sel_d];
      WAIT:    load_d = req_valid[sel_d];
      default: load_d = 1'b0;
    endcase
  end

  // Gated by reset so nothing pops while the block is held in reset.
  assign req_pop = (load_d && reset) ? (N'(1) << sel_d) : '0;

`ifdef ARB_XFER_STALL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
`ifdef ARB_XFER_STALL_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
`ifdef ARB_XFER_STALL_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      if (load_d) begin
        out_data_q <= req_data[int'(sel_d)*DW +: DW];
        out_last_q <= req_last[sel_d];
        out_id_q   <= sel_d;
      end
      case (state_q)
        IDLE: begin
          if (take_gnt) owner_q <= gnt_idx;
          if (load_d) begin
            state_q     <= SEND;
            out_valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
            end else if (!load_d) begin
              state_q     <= WAIT;
              out_valid_q <= 1'b0;
`ifdef ARB_XFER_STALL_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end
          end
        end
        WAIT: begin
          if (load_d) begin
            state_q     <= SEND;
            out_valid_q <= 1'b1;
          end
`ifdef ARB_XFER_STALL_TIMEOUT_EN
          else begin
            if (cnt_q != CW'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;
            if ((cnt_q + 1'b1) >= CW'(TIMEOUT)) begin
              state_q <= IDLE;
              err_q   <= 1'b1;
            end
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_arb_xfer_ctrl.sv
// Directed + random bench for arb_xfer_ctrl against an occupancy-based beat model.
// Build with ARB_XFER_STALL_TIMEOUT_EN defined to also cover the stall abort.
module tb_arb_xfer_ctrl;
  localparam int N = 4, DW = 32, TO = 4, IW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req_valid = '0, req_last = '0, gnt = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic              gnt_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0]      req_pop;
  logic              out_valid, out_last, busy, err_timeout;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_id;

  arb_xfer_ctrl #(.N(N), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .gnt(gnt), .gnt_valid(gnt_valid), .req_pop(req_pop),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .out_ready(out_ready), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int npass = 0, ntot = 0, nfail = 0;

  // Model: is a burst open, does the output register hold an undelivered beat.
  bit m_busy, m_full, m_last, m_err;
  int m_owner, m_id, m_wcnt;
  logic [DW-1:0] m_data;
  bit n_busy, n_full, n_last, n_err;
  int n_owner, n_id, n_wcnt;
  logic [DW-1:0] n_data;
  logic [N-1:0] exp_pop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_full = 0; m_last = 0; m_err = 0;
    m_owner = 0; m_id = 0; m_wcnt = 0; m_data = '0;
  endtask

  task automatic model_eval();
    int o;
    bit deliver, ended, consume;
    exp_pop = '0; consume = 0;
    deliver = m_full && out_ready;
    n_busy = m_busy; n_full = m_full; n_owner = m_owner; n_data = m_data;
    n_last = m_last; n_id = m_id; n_wcnt = m_wcnt; n_err = 0;
    if (!m_busy) begin
      if (gnt_valid && gnt != '0) begin
        o = 0;
        while (!gnt[o]) o++;
        n_owner = o;
        consume = req_valid[o];
      end
    end else begin
      ended = deliver && m_last;
      consume = !ended && (!m_full || deliver) && req_valid[m_owner];
    end
    if (consume) begin
      exp_pop[n_owner] = 1'b1;
      n_full = 1; n_busy = 1;
      n_data = req_data[n_owner*DW +: DW];
      n_last = req_last[n_owner];
      n_id = n_owner;
    end else if (deliver) begin
      n_full = 0; n_wcnt = 0;
      if (m_last) n_busy = 0;
    end else if (m_busy && !m_full) begin
`ifdef ARB_XFER_STALL_TIMEOUT_EN
      n_wcnt = m_wcnt + 1;
      if (n_wcnt >= TO) begin n_busy = 0; n_err = 1; end
`endif
    end
  endtask

  // Drive at negedge, then check the combinational pop against the model.
  task automatic drv(input logic [N-1:0] rv, input logic [N-1:0] rl,
                     input logic [N-1:0] g, input logic gv, input logic rdy);
    @(negedge clk);
    req_valid = rv; req_last = rl; gnt = g; gnt_valid = gv; out_ready = rdy;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    #1;
    model_eval();
    chk("req_pop", req_pop, exp_pop);
  endtask

  task automatic adv();
    @(posedge clk);
    m_busy = n_busy; m_full = n_full; m_owner = n_owner; m_data = n_data;
    m_last = n_last; m_id = n_id; m_wcnt = n_wcnt; m_err = n_err;
    #1;
    chk("out_valid", out_valid, m_full);
    chk("busy", busy, m_busy);
    chk("err_timeout", err_timeout, m_err);
    if (m_full) begin
      chk("out_data", out_data, m_data);
      chk("out_id", out_id, m_id);
      chk("out_last", out_last, m_last);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pop"}, req_pop, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_id"}, out_id, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask

  initial begin
    logic [DW-1:0] held;
    logic [N-1:0] rg;
    model_reset();
    #3 reset = 1'b0;
    #2 chk_all_zero("rst0");
    @(negedge clk) reset = 1'b1;

    // Single-beat burst on requester 1.
    drv(4'b0010, 4'b0010, 4'b0010, 1, 1);
    chk("t2_pop", req_pop, 4'b0010);
    adv();
    chk("t2_valid", out_valid, 1);
    chk("t2_id", out_id, 1);
    chk("t2_last", out_last, 1);
    drv(4'b0000, 4'b0000, 4'b0000, 0, 1); adv();
    chk("t2_bubble", out_valid, 0);

    // Three-beat burst on requester 2 with gnt wandering mid-burst.
    drv(4'b0100, 4'b0000, 4'b0100, 1, 1); chk("t3_pop0", req_pop, 4'b0100); adv();
    drv(4'b0100, 4'b0000, 4'b0001, 1, 1); chk("t3_pop1", req_pop, 4'b0100); adv();
    drv(4'b0100, 4'b0100, 4'b1000, 1, 1); chk("t3_pop2", req_pop, 4'b0100); adv();
    chk("t3_id", out_id, 2);
    drv(4'b0000, 4'b0000, 4'b0000, 0, 1); adv();

    // Backpressure for 5 cycles on requester 3.
    drv(4'b1000, 4'b0000, 4'b1000, 1, 0); adv();
    held = out_data;
    for (int k = 0; k < 5; k++) begin
      drv(4'b1000, 4'b1000, 4'b0001, 1, 0);
      chk("t4_nopop", req_pop, 0);
      adv();
      chk("t4_hold", out_data, held);
    end
    drv(4'b1000, 4'b1000, 4'b0000, 0, 1); chk("t4_pop", req_pop, 4'b1000); adv();
    drv(4'b0000, 4'b0000, 4'b0000, 0, 1); adv();

    // Source stall on requester 0, then resume.
    drv(4'b0001, 4'b0000, 4'b0001, 1, 1); adv();
    drv(4'b0000, 4'b0000, 4'b0000, 0, 1); adv();
    chk("t5_wait_valid", out_valid, 0);
    chk("t5_wait_busy", busy, 1);
    drv(4'b0000, 4'b0000, 4'b0010, 1, 1); adv();
    drv(4'b0001, 4'b0001, 4'b0000, 0, 0); adv();
    chk("t5_id", out_id, 0);
    drv(4'b0000, 4'b0000, 4'b0000, 0, 1); adv();

`ifdef ARB_XFER_STALL_TIMEOUT_EN
    drv(4'b0010, 4'b0000, 4'b0010, 1, 1); adv();
    drv(4'b0000, 4'b0000, 4'b0000, 0, 1); adv();
    for (int k = 1; k <= 4; k++) begin
      drv(4'b0000, 4'b0000, 4'b0000, 0, 1); adv();
      chk("t6_err", err_timeout, (k == 4));
    end
    drv(4'b0100, 4'b0100, 4'b0100, 1, 1); chk("t6_regrant", req_pop, 4'b0100); adv();
    drv(4'b0000, 4'b0000, 4'b0000, 0, 1); adv();
`endif

    // Reset while SEND holds a beat.
    drv(4'b0010, 4'b0000, 4'b0010, 1, 0); adv();
    @(negedge clk);
    reset = 1'b0; req_valid = '1; gnt_valid = 1'b1; gnt = 4'b0001;
    #1 chk_all_zero("rst_mid");
    model_reset();
    @(negedge clk);
    reset = 1'b1; gnt_valid = 1'b0; req_valid = '0;
    drv(4'b0000, 4'b0000, 4'b0000, 0, 1); adv();

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(3) != 0) rg = N'(1) << $urandom_range(N-1);
      else rg = N'($urandom);
      drv(N'($urandom) | N'($urandom), N'($urandom) & N'($urandom), rg,
          1'($urandom), ($urandom_range(9) < 7));
      adv();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
